// File: rtl/sd_image_reader.sv
// rtl/sd_image_reader.sv - fetches a fixed run of SD sectors and streams the words into the image FIFO
module sd_image_reader #(
  parameter logic [31:0] START_SEC = 32'd20000,
  parameter logic [15:0] SEC_NUM   = 16'd1200,
  parameter logic [10:0] SPACE_TH  = 11'd1536
) (
  input  logic        SD_clk_ref,
  input  logic        sys_rst_n,
  input  logic        sd_init_done,
  input  logic        sys_image_read_req,
  input  logic        rd_busy,
  input  logic        rd_val_en,
  input  logic [15:0] rd_val_data,
  output logic        rd_start_en,
  output logic [31:0] rd_sec_addr,
  input  logic        rd_sdfifo_full_flag,
  input  logic [10:0] rd_sdfifo_len,
  output logic        rd_sd_wfifo_req_en,
  output logic [15:0] rd_sd_wfifo_data,
  output logic        rd_sd_image_done_n,
  output logic [15:0] sec_cnt,
  output logic        rd_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SPACE,
    ST_START,
    ST_WAIT_BUSY_H,
    ST_WAIT_BUSY_L,
    ST_NEXT,
    ST_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_req_d;
  logic        r_start_en;
  logic [31:0] r_sec_addr;
  logic [15:0] r_sec_cnt;
  logic [8:0]  r_word_cnt;
  logic        r_wr_en;
  logic [15:0] r_wr_data;
  logic        r_done_n;
  logic        r_err;

  logic        w_req_rise;
  logic        w_accept;
  logic        w_in_sector;
  logic        w_word_in;
  logic        w_space_ok;
  logic [15:0] w_sec_cnt_inc;
  logic        w_last_sec;

  // A request is only honoured while no image transfer is in flight.
  assign w_req_rise    = sys_image_read_req & ~r_req_d;
  assign w_accept      = w_req_rise & sd_init_done &
                         ((r_state == ST_IDLE) || (r_state == ST_DONE));
  // Words are only accepted between the start pulse and the end of the sector.
  assign w_in_sector   = (r_state == ST_WAIT_BUSY_H) || (r_state == ST_WAIT_BUSY_L);
  assign w_word_in     = rd_val_en & w_in_sector;
  // A whole sector (256 words) must fit before it is requested.
  assign w_space_ok    = (rd_sdfifo_len < SPACE_TH) & ~rd_sdfifo_full_flag & ~rd_busy;
  assign w_sec_cnt_inc = r_sec_cnt + 16'd1;
  assign w_last_sec    = (w_sec_cnt_inc == SEC_NUM);

  assign rd_start_en        = r_start_en;
  assign rd_sec_addr        = r_sec_addr;
  assign rd_sd_wfifo_req_en = r_wr_en;
  assign rd_sd_wfifo_data   = r_wr_data;
  assign rd_sd_image_done_n = r_done_n;
  assign sec_cnt            = r_sec_cnt;
  assign rd_err             = r_err;

  // State register.
  always_ff @(posedge SD_clk_ref or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_next_state;
  end

  // Next-state decode for the sector sequencing.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_accept) w_next_state = ST_WAIT_SPACE;
      ST_WAIT_SPACE:    if (w_space_ok) w_next_state = ST_START;
      ST_START:         w_next_state = ST_WAIT_BUSY_H;
      ST_WAIT_BUSY_H:   if (rd_busy) w_next_state = ST_WAIT_BUSY_L;
      ST_WAIT_BUSY_L:   if (!rd_busy) w_next_state = ST_NEXT;
      ST_NEXT:          w_next_state = w_last_sec ? ST_DONE : ST_WAIT_SPACE;
      default:          w_next_state = ST_IDLE;
    endcase
  end

  // Request edge detector and the one-cycle sector start pulse.
  always_ff @(posedge SD_clk_ref or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_req_d    <= 1'b0;
      r_start_en <= 1'b0;
    end else begin
      r_req_d    <= sys_image_read_req;
      r_start_en <= (w_next_state == ST_START);
    end
  end

  // Per-sector word counter, cleared as each sector is launched.
  always_ff @(posedge SD_clk_ref or negedge sys_rst_n) begin
    if (!sys_rst_n)                 r_word_cnt <= 9'd0;
    else if (r_state == ST_START)   r_word_cnt <= 9'd0;
    else if (w_word_in)             r_word_cnt <= r_word_cnt + 9'd1;
  end

  // Registered FIFO write; a word arriving while the FIFO is full is dropped.
  always_ff @(posedge SD_clk_ref or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_data <= 16'd0;
    end else begin
      r_wr_en <= w_word_in & ~rd_sdfifo_full_flag;
      if (w_word_in && !rd_sdfifo_full_flag) r_wr_data <= rd_val_data;
    end
  end

  // Image progress: sector address, completed-sector count and done flag.
  always_ff @(posedge SD_clk_ref or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sec_addr <= START_SEC;
      r_sec_cnt  <= 16'd0;
      r_done_n   <= 1'b1;
    end else if (w_accept) begin
      r_sec_addr <= START_SEC;
      r_sec_cnt  <= 16'd0;
      r_done_n   <= 1'b1;
    end else if (r_state == ST_NEXT) begin
      r_sec_addr <= r_sec_addr + 32'd1;
      r_sec_cnt  <= w_sec_cnt_inc;
      if (w_last_sec) r_done_n <= 1'b0;
    end
  end

  // Sticky error: short/long sector or a word lost to a full FIFO.
  always_ff @(posedge SD_clk_ref or negedge sys_rst_n) begin
    if (!sys_rst_n)
      r_err <= 1'b0;
    else if (w_accept)
      r_err <= 1'b0;
    else if (((r_state == ST_NEXT) && (r_word_cnt != 9'd256)) ||
             (w_word_in && rd_sdfifo_full_flag))
      r_err <= 1'b1;
  end

endmodule

// File: tb/tb_sd_image_reader.sv
// tb/tb_sd_image_reader.sv - randomized self-checking bench for sd_image_reader
module tb_sd_image_reader;

  localparam logic [31:0] START = 32'd100;
  localparam int          NSEC  = 3;

  logic        clk = 1'b0;
  logic        sys_rst_n;
  logic        sd_init_done;
  logic        sys_image_read_req;
  logic        rd_busy;
  logic        rd_val_en;
  logic [15:0] rd_val_data;
  logic        rd_start_en;
  logic [31:0] rd_sec_addr;
  logic        rd_sdfifo_full_flag;
  logic [10:0] rd_sdfifo_len;
  logic        rd_sd_wfifo_req_en;
  logic [15:0] rd_sd_wfifo_data;
  logic        rd_sd_image_done_n;
  logic [15:0] sec_cnt;
  logic        rd_err;

  sd_image_reader #(
    .START_SEC(START),
    .SEC_NUM  (16'(NSEC)),
    .SPACE_TH (11'd1536)
  ) dut (
    .SD_clk_ref         (clk),
    .sys_rst_n          (sys_rst_n),
    .sd_init_done       (sd_init_done),
    .sys_image_read_req (sys_image_read_req),
    .rd_busy            (rd_busy),
    .rd_val_en          (rd_val_en),
    .rd_val_data        (rd_val_data),
    .rd_start_en        (rd_start_en),
    .rd_sec_addr        (rd_sec_addr),
    .rd_sdfifo_full_flag(rd_sdfifo_full_flag),
    .rd_sdfifo_len      (rd_sdfifo_len),
    .rd_sd_wfifo_req_en (rd_sd_wfifo_req_en),
    .rd_sd_wfifo_data   (rd_sd_wfifo_data),
    .rd_sd_image_done_n (rd_sd_image_done_n),
    .sec_cnt            (sec_cnt),
    .rd_err             (rd_err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errs   = 0;
  int          n_starts = 0;
  int          n_writes = 0;
  bit          start_seen;
  bit          exp_wr;
  bit          exp_err;
  logic [31:0] exp_addr;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample DUT outputs at the falling edge, then the caller drives.
  task automatic cyc();
    @(negedge clk);
    if (rd_start_en) begin
      n_starts++;
      start_seen = 1'b1;
      check("start_addr", rd_sec_addr, exp_addr);
    end
    check("wr_en", 32'(rd_sd_wfifo_req_en), 32'(exp_wr));
    if (rd_sd_wfifo_req_en) begin
      n_writes++;
      if (exp_q.size() > 0) check("wr_data", 32'(rd_sd_wfifo_data), 32'(exp_q.pop_front()));
      else                  check("wr_unexpected", 32'd1, 32'd0);
    end
    exp_wr = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_start"},  32'(rd_start_en), 32'd0);
    check({tag, "_addr"},   rd_sec_addr, START);
    check({tag, "_wr_en"},  32'(rd_sd_wfifo_req_en), 32'd0);
    check({tag, "_data"},   32'(rd_sd_wfifo_data), 32'd0);
    check({tag, "_done_n"}, 32'(rd_sd_image_done_n), 32'd1);
    check({tag, "_sec"},    32'(sec_cnt), 32'd0);
    check({tag, "_err"},    32'(rd_err), 32'd0);
  endtask

  task automatic wait_start(input int budget);
    start_seen = 1'b0;
    for (int k = 0; k < budget && !start_seen; k++) cyc();
    check("start_seen", 32'(start_seen), 32'd1);
  endtask

  task automatic reset_abort();
    int s0;
    s0 = n_starts;
    rd_val_en   = 1'b1;
    rd_val_data = 16'($urandom);
    sys_rst_n   = 1'b0;
    #1;
    check_reset("abort");
    repeat (4) cyc();
    sys_rst_n = 1'b1;
    repeat (4) begin
      rd_val_data = 16'($urandom);
      cyc();
    end
    rd_val_en = 1'b0;
    rd_busy   = 1'b0;
    repeat (6) cyc();
    check("abort_no_start", 32'(n_starts - s0), 32'd0);
    check("abort_q_empty", 32'(exp_q.size()), 32'd0);
    check_reset("post_abort");
  endtask

  // Controller model for one sector plus the expected effect on the FIFO side.
  task automatic run_sector(input int idx, input int nwords, input int full_at,
                            input bit req_mid, input int rst_at, input int budget);
    bit together;
    bit f;
    exp_addr = START + 32'(idx);
    wait_start(budget);
    repeat ($urandom_range(1, 3)) cyc();
    rd_busy = 1'b1;
    cyc();
    together = 1'($urandom_range(0, 1));
    for (int i = 0; i < nwords; i++) begin
      repeat ($urandom_range(0, 2)) cyc();
      if (i == rst_at) begin
        reset_abort();
        return;
      end
      f = (full_at >= 0) && (i >= full_at) && (i < full_at + 4);
      rd_val_en           = 1'b1;
      rd_val_data         = 16'($urandom);
      rd_sdfifo_full_flag = f;
      if (f) exp_err = 1'b1;
      else begin
        exp_q.push_back(rd_val_data);
        exp_wr = 1'b1;
      end
      if (req_mid && i == 20) sys_image_read_req = 1'b1;
      if (i == nwords - 1 && together) rd_busy = 1'b0;
      cyc();
      rd_val_en           = 1'b0;
      rd_sdfifo_full_flag = 1'b0;
      sys_image_read_req  = 1'b0;
    end
    if (rd_busy) begin
      rd_busy = 1'b0;
      cyc();
    end
    cyc();
    if (nwords != 256) exp_err = 1'b1;
    check("sec_cnt", 32'(sec_cnt), 32'(idx + 1));
    check("sec_err", 32'(rd_err), 32'(exp_err));
    check("sec_done_n", 32'(rd_sd_image_done_n), (idx == NSEC - 1) ? 32'd0 : 32'd1);
    check("sec_addr_inc", rd_sec_addr, START + 32'(idx + 1));
  endtask

  task automatic run_image(input int bad_sec, input int full_sec, input bit stall,
                           input bit req_mid, input int exp_total);
    int w0;
    int s0;
    w0 = n_writes;
    s0 = n_starts;
    sys_image_read_req = 1'b1;
    cyc();
    sys_image_read_req = 1'b0;
    check("acc_done_n", 32'(rd_sd_image_done_n), 32'd1);
    check("acc_sec_cnt", 32'(sec_cnt), 32'd0);
    check("acc_err", 32'(rd_err), 32'd0);
    check("acc_addr", rd_sec_addr, START);
    exp_err = 1'b0;
    for (int s = 0; s < NSEC; s++) begin
      run_sector(s, (s == bad_sec) ? 255 : 256, (s == full_sec) ? 100 : -1,
                 req_mid && (s == 1), -1, (stall && s == 1) ? 3 : 200);
      if (stall && s == 0) begin
        rd_sdfifo_len = 11'd1600;
        repeat (20) cyc();
        check("stall_no_start", 32'(n_starts - s0), 32'd1);
        rd_sdfifo_len = 11'd1535;
      end
    end
    rd_sdfifo_len = 11'd0;
    repeat (5) cyc();
    check("img_done_n", 32'(rd_sd_image_done_n), 32'd0);
    check("img_sec_cnt", 32'(sec_cnt), 32'(NSEC));
    check("img_starts", 32'(n_starts - s0), 32'(NSEC));
    check("img_writes", 32'(n_writes - w0), 32'(exp_total));
    check("img_q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n           = 1'b0;
    sd_init_done        = 1'b0;
    sys_image_read_req  = 1'b0;
    rd_busy             = 1'b0;
    rd_val_en           = 1'b0;
    rd_val_data         = 16'd0;
    rd_sdfifo_full_flag = 1'b0;
    rd_sdfifo_len       = 11'd0;
    exp_wr              = 1'b0;
    exp_err             = 1'b0;
    exp_addr            = START;
    repeat (3) @(negedge clk);
    check_reset("rst");
    sys_rst_n = 1'b1;
    repeat (2) cyc();

    sys_image_read_req = 1'b1;
    repeat (2) cyc();
    sys_image_read_req = 1'b0;
    repeat (10) cyc();
    check("noinit_starts", 32'(n_starts), 32'd0);
    check("noinit_done_n", 32'(rd_sd_image_done_n), 32'd1);
    sd_init_done = 1'b1;
    repeat (2) cyc();

    run_image(-1, -1, 1'b1, 1'b1, 768);
    run_image(1, -1, 1'b0, 1'b0, 767);
    check("short_err", 32'(rd_err), 32'd1);
    run_image(-1, 2, 1'b0, 1'b0, 764);
    check("full_err", 32'(rd_err), 32'd1);

    sys_image_read_req = 1'b1;
    cyc();
    sys_image_read_req = 1'b0;
    exp_err = 1'b0;
    run_sector(0, 256, -1, 1'b0, -1, 200);
    run_sector(1, 256, -1, 1'b0, 50, 200);

    run_image(-1, -1, 1'b0, 1'b0, 768);
    check("final_err", 32'(rd_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/sd_image_reader.md
# sd_image_reader

Read-side image engine for the SD card path: on an image read request it fetches a fixed run of consecutive 512-byte sectors through the SD controller's user read port. It streams the 16-bit words into the 16-bit-write / 32-bit-read image FIFO. Each sector starts only when the FIFO has room for all 256 words. The block sits beside the SD write-path data generator, driving the `rd_start_en`/`rd_sec_addr` side of the SD controller and the `rd_sd_wfifo_*` side of the FIFO.

## Interface
- `START_SEC`, 32'd20000, first sector address of the stored image
- `SEC_NUM`, 16'd1200, sectors per image (must be ≥ 1)
- `SPACE_TH`, 11'd1536, a sector may start only when `rd_sdfifo_len` < this value
- `SD_clk_ref`  in  1  sole clock (SD controller reference clock); all logic on rising edge
- `sys_rst_n`  in  1  asynchronous, active-low reset
- `sd_init_done`  in  1  SD card initialised; requests ignored while low
- `sys_image_read_req`  in  1  read request, synchronous to `SD_clk_ref`, rising-edge detected
- `rd_busy`  in  1  SD controller read in progress
- `rd_val_en`  in  1  read word valid
- `rd_val_data`  in  16  read word
- `rd_start_en`  out  1  one-cycle sector-read start pulse
- `rd_sec_addr`  out  32  sector address, stable from pulse until `rd_busy` falls
- `rd_sdfifo_full_flag`  in  1  image FIFO full
- `rd_sdfifo_len`  in  11  image FIFO write-side fill level (words)
- `rd_sd_wfifo_req_en`  out  1  FIFO write enable
- `rd_sd_wfifo_data`  out  16  FIFO write data
- `rd_sd_image_done_n`  out  1  low = whole image delivered
- `sec_cnt`  out  16  sectors completed in current image
- `rd_err`  out  1  sticky: word-count mismatch or FIFO overflow

## Operation
- States: IDLE, WAIT_SPACE, START, WAIT_BUSY_H, WAIT_BUSY_L, NEXT, DONE.
- IDLE / DONE:
  - A rising edge of `sys_image_read_req` with `sd_init_done`=1 loads `rd_sec_addr`=`START_SEC`, clears `sec_cnt` and `rd_err`, drives `rd_sd_image_done_n`=1, and moves to WAIT_SPACE.
  - An edge while `sd_init_done`=0 is dropped.
  - An edge in any other state is dropped.
- WAIT_SPACE: once `rd_sdfifo_len` < `SPACE_TH`, `rd_sdfifo_full_flag`=0 and `rd_busy`=0, go to START.
- START: assert `rd_start_en` for exactly one cycle, clear the per-sector word counter (9 bits), go to WAIT_BUSY_H.
- WAIT_BUSY_H: wait for `rd_busy`=1, then go to WAIT_BUSY_L.
- WAIT_BUSY_L:
  - Each `rd_val_en` cycle increments the word counter.
  - When `rd_busy`=0, go to NEXT.
- NEXT:
  - If the word count ≠ 256, set `rd_err`.
  - Increment `sec_cnt` and `rd_sec_addr` (32-bit wrap allowed).
  - If the new `sec_cnt` == `SEC_NUM`, go to DONE and drive `rd_sd_image_done_n`=0; otherwise go to WAIT_SPACE.
- DONE: `rd_sd_image_done_n` stays 0 until the next accepted request.
- FIFO path:
  - `rd_val_en`=1 in WAIT_BUSY_H or WAIT_BUSY_L with `rd_sdfifo_full_flag`=0 writes the word: `rd_sd_wfifo_req_en`=1 and `rd_sd_wfifo_data`=`rd_val_data`, both registered.
  - `rd_val_en`=1 while full: the word is dropped and `rd_err` is set.
  - `rd_val_en` in any other state is ignored and not counted.
- Reset mid-image aborts immediately with no partial completion.

## Timing
- Reset values:
  - state = IDLE
  - `rd_start_en`=0
  - `rd_sec_addr`=`START_SEC`
  - `rd_sd_wfifo_req_en`=0
  - `rd_sd_wfifo_data`=0
  - `rd_sd_image_done_n`=1
  - `sec_cnt`=0
  - `rd_err`=0
- Request edge is detected by a one-flop delay; IDLE→WAIT_SPACE occurs on the edge after the request's first high cycle.
- WAIT_SPACE→START takes 1 cycle once conditions hold; `rd_start_en` is high in the START cycle only.
- FIFO write latency is exactly 1 cycle: `rd_val_en` at edge n gives `rd_sd_wfifo_req_en` high at edge n+1. Back-to-back valid words give back-to-back writes.
- `rd_busy` falling and the final `rd_val_en` in the same cycle: the word is counted and written before the NEXT check.
- `rd_sd_image_done_n` falls on the cycle after NEXT of the last sector.
- `SPACE_TH` ≤ 2048−256 guarantees no overflow, because full is checked only at sector start.

## Test plan
- `SEC_NUM`=3, `START_SEC`=100, controller model returns 256 words/sector, FIFO len 0:
  - 3 `rd_start_en` pulses at addresses 100, 101, 102.
  - 768 FIFO writes, data equal to the model's, each 1 cycle late.
  - `rd_sd_image_done_n`=0, `sec_cnt`=3, `rd_err`=0.
- Hold `rd_sdfifo_len`=1600 after sector 1: no second `rd_start_en` until len drops to 1535, then pulse on the next cycles.
- Model returns 255 words on sector 2 → `rd_err`=1 after that sector; the transfer still completes with 3 sectors.
- Assert `rd_sdfifo_full_flag` for 4 words mid-sector → those 4 are not written and `rd_err`=1.
- Request pulse with `sd_init_done`=0, then a second request during WAIT_BUSY_L → both ignored; a request after DONE restarts at `START_SEC` with done_n back to 1.
- `sys_rst_n` low mid-sector → all outputs at reset values the same cycle; no further FIFO writes.
